// File: rtl/flash_pkg.sv
// Shared constants and encodings for the StrataFlash byte port.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flash_pkg;

  // StrataFlash command bytes (byte-mode bus)
  localparam logic [7:0] CMD_PROGRAM    = 8'h40;
  localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;

  // STS may lag the program command; don't trust it for this many cycles.
  localparam int STS_IGNORE = 4;

  typedef enum logic [3:0] {
    S_INIT,
    S_INIT_CLR,
    S_IDLE,
    S_RD,
    S_WR_CMD,
    S_WR_DAT,
    S_WR_BUSY,
    S_WR_CLR,
    S_DONE
  } fsm_state_e;

  typedef enum logic [2:0] {
    B_IDLE,
    B_RD,
    B_SETUP,
    B_WE,
    B_HOLD,
    B_REL
  } bus_phase_e;

  // Width of a counter able to reach the largest of three cycle counts.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// One timed StrataFlash byte-mode bus cycle: array read or WE-strobed write.
// Latency: read done T_ACC cycles after start; write done T_WP+3 cycles after start.
// Backpressure: start is only honoured while idle; caller waits for the done pulse.
// Ports: clk/rst; start, we, addr, wdata in; done (1-cycle), rdata out;
//        sf_a, sf_d (inout), sf_ce0, sf_oe, sf_we drive the flash pins.
module flash_bus_cycle
  import flash_pkg::*;
#(
  parameter int          T_ACC     = 6,
  parameter int          T_WP      = 3,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [7:0]  wdata,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [23:0] sf_a,
  inout  wire  [7:0]  sf_d,
  output logic        sf_ce0,
  output logic        sf_oe,
  output logic        sf_we
);

  localparam int CW = cnt_w(T_ACC, T_WP, 1);

  bus_phase_e    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ce_q, ce_d, oe_q, oe_d, we_q, we_d;
  logic          drv_q, drv_d, done_q, done_d;
  logic [23:0]   a_q, a_d;
  logic [7:0]    d_q, d_d, rdata_q, rdata_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    ce_d    = ce_q;
    oe_d    = oe_q;
    we_d    = we_q;
    drv_d   = drv_q;
    done_d  = 1'b0;
    a_d     = a_q;
    d_d     = d_q;
    rdata_d = rdata_q;
    unique case (phase_q)
      B_IDLE: begin
        if (start) begin
          a_d   = {BASE_ADDR, addr};
          cnt_d = '0;
          ce_d  = 1'b0;
          if (we) begin
            d_d     = wdata;
            drv_d   = 1'b1;
            phase_d = B_SETUP;
          end else begin
            oe_d    = 1'b0;
            phase_d = B_RD;
          end
        end
      end
      B_RD: begin
        if (cnt_q == CW'(T_ACC - 1)) begin
          rdata_d = sf_d;
          ce_d    = 1'b1;
          oe_d    = 1'b1;
          done_d  = 1'b1;
          phase_d = B_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // address/data already stable with CE low; open the WE strobe
      B_SETUP: begin
        we_d    = 1'b0;
        phase_d = B_WE;
      end
      B_WE: begin
        if (cnt_q == CW'(T_WP - 1)) begin
          we_d    = 1'b1;
          phase_d = B_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      B_HOLD: begin
        ce_d    = 1'b1;
        phase_d = B_REL;
      end
      // data held one cycle past CE rising, then released
      B_REL: begin
        drv_d   = 1'b0;
        done_d  = 1'b1;
        phase_d = B_IDLE;
      end
      default: phase_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= B_IDLE;
      cnt_q   <= '0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      drv_q   <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      rdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      drv_q   <= drv_d;
      done_q  <= done_d;
      a_q     <= a_d;
      d_q     <= d_d;
      rdata_q <= rdata_d;
    end
  end

  assign done   = done_q;
  assign rdata  = rdata_q;
  assign sf_a   = a_q;
  assign sf_ce0 = ce_q;
  assign sf_oe  = oe_q;
  assign sf_we  = we_q;
  assign sf_d   = drv_q ? d_q : 8'hzz;

endmodule

// File: rtl/flash_byte_port.sv
// MANAGER flash request responder: sequences byte reads and 0x40/data/STS/0xFF programs.
// Latency: read 1+T_ACC+1 cycles trigger-to-status; write 3 bus cycles + STS wait + 1.
// Backpressure: FL_TRG only sampled in IDLE; triggers while busy are dropped, not queued.
// Ports: CLK_50MHZ, RST (async, high); FL_TRG/FL_FLOW/FL_ADDR/FL_DATA request bus,
//        FL_STATUS done pulse, FL_ERR sticky timeout; SF_* StrataFlash pins, SF_STS ready.
module flash_byte_port
  import flash_pkg::*;
#(
  parameter int          T_ACC     = 6,
  parameter int          T_WP      = 3,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          TIMEOUT   = 1_000_000
) (
  input  logic        CLK_50MHZ,
  input  logic        RST,
  input  logic        FL_TRG,
  input  logic        FL_FLOW,
  input  logic [7:0]  FL_ADDR,
  inout  wire  [7:0]  FL_DATA,
  output logic        FL_STATUS,
  output logic        FL_ERR,
  output logic [23:0] SF_A,
  inout  wire  [7:0]  SF_D,
  output logic        SF_CE0,
  output logic        SF_OE,
  output logic        SF_WE,
  output logic        SF_BYTE,
  input  logic        SF_STS
);

  localparam int TW = cnt_w(T_ACC, T_WP, TIMEOUT);

  fsm_state_e    state_q;
  logic          start_q, cyc_we_q, fl_status_q, fl_err_q;
  logic [7:0]    cyc_wdata_q, addr_q, wbyte_q, rd_data_q;
  logic [TW-1:0] tcnt_q;
  logic          sts_meta_q, sts_sync_q;
  logic          cyc_done;
  logic [7:0]    cyc_rdata;
  logic          sts_ready, sts_timeout;

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      sts_meta_q <= 1'b0;
      sts_sync_q <= 1'b0;
    end else begin
      sts_meta_q <= SF_STS;
      sts_sync_q <= sts_meta_q;
    end
  end

  assign sts_ready   = (tcnt_q >= TW'(STS_IGNORE)) && sts_sync_q;
  assign sts_timeout = (tcnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state_q     <= S_INIT;
      start_q     <= 1'b0;
      cyc_we_q    <= 1'b0;
      cyc_wdata_q <= '0;
      addr_q      <= '0;
      wbyte_q     <= '0;
      rd_data_q   <= '0;
      tcnt_q      <= '0;
      fl_status_q <= 1'b0;
      fl_err_q    <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      fl_status_q <= 1'b0;
      case (state_q)
        // A program may still be running inside the chip after a reset;
        // read-array is only accepted once STS reports ready.
        S_INIT: begin
          if (sts_sync_q) begin
            start_q     <= 1'b1;
            cyc_we_q    <= 1'b1;
            cyc_wdata_q <= CMD_READ_ARRAY;
            state_q     <= S_INIT_CLR;
          end
        end
        S_INIT_CLR: if (cyc_done) state_q <= S_IDLE;
        S_IDLE: begin
          if (FL_TRG) begin
            addr_q   <= FL_ADDR;
            fl_err_q <= 1'b0;
            start_q  <= 1'b1;
            if (FL_FLOW) begin
              cyc_we_q <= 1'b0;
              state_q  <= S_RD;
            end else begin
              wbyte_q     <= FL_DATA;
              cyc_we_q    <= 1'b1;
              cyc_wdata_q <= CMD_PROGRAM;
              state_q     <= S_WR_CMD;
            end
          end
        end
        S_RD: begin
          if (cyc_done) begin
            rd_data_q   <= cyc_rdata;
            fl_status_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_WR_CMD: begin
          if (cyc_done) begin
            start_q     <= 1'b1;
            cyc_wdata_q <= wbyte_q;
            state_q     <= S_WR_DAT;
          end
        end
        S_WR_DAT: begin
          if (cyc_done) begin
            tcnt_q  <= '0;
            state_q <= S_WR_BUSY;
          end
        end
        S_WR_BUSY: begin
          tcnt_q <= tcnt_q + TW'(1);
          if (sts_ready || sts_timeout) begin
            if (!sts_ready) fl_err_q <= 1'b1;
            start_q     <= 1'b1;
            cyc_wdata_q <= CMD_READ_ARRAY;
            state_q     <= S_WR_CLR;
          end
        end
        S_WR_CLR: begin
          if (cyc_done) begin
            fl_status_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_INIT;
      endcase
    end
  end

  flash_bus_cycle #(
    .T_ACC     (T_ACC),
    .T_WP      (T_WP),
    .BASE_ADDR (BASE_ADDR)
  ) u_bus (
    .clk    (CLK_50MHZ),
    .rst    (RST),
    .start  (start_q),
    .we     (cyc_we_q),
    .addr   (addr_q),
    .wdata  (cyc_wdata_q),
    .done   (cyc_done),
    .rdata  (cyc_rdata),
    .sf_a   (SF_A),
    .sf_d   (SF_D),
    .sf_ce0 (SF_CE0),
    .sf_oe  (SF_OE),
    .sf_we  (SF_WE)
  );

  assign FL_STATUS = fl_status_q;
  assign FL_ERR    = fl_err_q;
  assign SF_BYTE   = 1'b0;
  assign FL_DATA   = FL_FLOW ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_flash_byte_port.sv
// Bench for flash_byte_port: pin-level StrataFlash model plus transaction-level
// reference memory; a monitor process scores every FL_STATUS pulse and bus rule.
module tb_flash_byte_port;

  localparam int T_ACC     = 6;
  localparam int T_WP      = 3;
  localparam int TIMEOUT   = 100;
  localparam int PROG_BUSY = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fl_trg = 1'b0;
  logic        fl_flow = 1'b1;
  logic [7:0]  fl_addr = 8'h00;
  logic [7:0]  wr_dat = 8'h00;
  wire  [7:0]  fl_data;
  wire  [7:0]  sf_d;
  logic        fl_status, fl_err, sf_ce0, sf_oe, sf_we, sf_byte, sf_sts;
  logic [23:0] sf_a;

  always #5 clk = ~clk;

  assign fl_data = fl_flow ? 8'hzz : wr_dat;

  flash_byte_port #(
    .T_ACC(T_ACC), .T_WP(T_WP), .BASE_ADDR(16'h0000), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK_50MHZ(clk), .RST(rst), .FL_TRG(fl_trg), .FL_FLOW(fl_flow),
    .FL_ADDR(fl_addr), .FL_DATA(fl_data), .FL_STATUS(fl_status), .FL_ERR(fl_err),
    .SF_A(sf_a), .SF_D(sf_d), .SF_CE0(sf_ce0), .SF_OE(sf_oe), .SF_WE(sf_we),
    .SF_BYTE(sf_byte), .SF_STS(sf_sts)
  );

  // ---------------- flash device model ----------------
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  bit loaded = 1'b0, status_mode = 1'b0, expect_data = 1'b0, force_busy = 1'b0;
  bit m_we_prev = 1'b1;
  int busy = 0;

  assign sf_sts = !(force_busy || busy > 0);
  assign sf_d = (!sf_ce0 && !sf_oe) ? (status_mode ? {sf_sts, 7'b0} : mem[sf_a[7:0]]) : 8'hzz;

  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
      loaded <= 1'b1;
    end
    m_we_prev <= sf_we;
    if (busy > 0) busy <= busy - 1;
    // commands latch on WE rising; chip ignores commands while programming
    if (sf_we && !m_we_prev && busy == 0) begin
      if (expect_data) begin
        mem[sf_a[7:0]] <= sf_d;
        busy           <= PROG_BUSY;
        status_mode    <= 1'b1;
        expect_data    <= 1'b0;
      end else if (sf_d == 8'h40) begin
        expect_data <= 1'b1;
        status_mode <= 1'b1;
      end else if (sf_d == 8'hFF) begin
        status_mode <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  typedef struct {
    bit         is_rd;
    logic [7:0] data;
    bit         err;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] we_log[$];
  bit         sts_log[$];
  int checks = 0, failures = 0, status_cnt = 0, bus_viol = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: scoreboard pops on FL_STATUS, OE pulse width, write log, OE/WE overlap
  initial begin
    int   oe_run;
    bit   we_prev;
    exp_t e;
    oe_run  = 0;
    we_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        oe_run  = 0;
        we_prev = sf_we;
      end else begin
        if (!sf_oe) oe_run++;
        else if (oe_run > 0) begin
          chk("oe_low_cycles", oe_run, T_ACC);
          oe_run = 0;
        end
        if (sf_we && !we_prev) begin
          we_log.push_back(sf_d);
          sts_log.push_back(sf_sts);
        end
        we_prev = sf_we;
        if (!sf_oe && !sf_we) bus_viol++;
        if (fl_status) begin
          status_cnt++;
          if (sb_q.size() == 0) chk("unexpected_status", 1, 0);
          else begin
            e = sb_q.pop_front();
            if (e.is_rd) chk("rd_data", fl_data, e.data);
            chk("err_flag", fl_err, e.err);
          end
        end
      end
    end
  end

  // Issue one request and wait for its status pulse. repulse re-strobes FL_TRG mid-op.
  task automatic do_op(input bit rd, input logic [7:0] a, input logic [7:0] d,
                       input bit exp_err, input bit repulse, output int lat);
    exp_t e;
    int   s0;
    e.is_rd = rd;
    e.data  = ref_mem[a];
    e.err   = exp_err;
    if (!rd) ref_mem[a] = d;
    sb_q.push_back(e);
    s0 = status_cnt;
    @(posedge clk); #1;
    fl_flow = rd; fl_addr = a; wr_dat = d; fl_trg = 1'b1;
    @(posedge clk); #1;
    fl_trg  = 1'b0;
    fl_addr = 8'($urandom);   // must not matter once latched
    wr_dat  = 8'($urandom);
    chk("err_cleared_on_accept", fl_err, 0);
    lat = 0;
    while (!fl_status && lat < 600) begin
      fl_trg = (repulse && lat == 25);
      @(posedge clk); #1;
      lat++;
    end
    fl_trg = 1'b0;
    if (!fl_status) chk("op_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("status_pulses", status_cnt - s0, 1);
  endtask

  task automatic check_wlog(input int n0, input logic [7:0] d);
    chk("we_cycles", we_log.size() - n0, 3);
    if (we_log.size() - n0 == 3) begin
      chk("we_seq_cmd", we_log[n0], 8'h40);
      chk("we_seq_dat", we_log[n0 + 1], d);
      chk("we_seq_clr", we_log[n0 + 2], 8'hFF);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         lat, n0, n1, w;
    logic [7:0] a, d, ta, td;
    bit         rd;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    ref_mem[8'h12] = 8'hA5;

    // reset state
    @(posedge clk); #1;
    chk("rst_ce", sf_ce0, 1);
    chk("rst_oe", sf_oe, 1);
    chk("rst_we", sf_we, 1);
    chk("rst_addr", sf_a, 0);
    chk("rst_status", fl_status, 0);
    chk("rst_err", fl_err, 0);
    chk("rst_byte", sf_byte, 0);
    chk("rst_rd_data", fl_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // power-up read-array command
    w = 0;
    while (we_log.size() < 1 && w < 100) begin @(posedge clk); #1; w++; end
    chk("init_cmd_seen", we_log.size(), 1);
    if (we_log.size() >= 1) chk("init_cmd", we_log[0], 8'hFF);
    repeat (4) @(posedge clk);

    // directed read and write
    do_op(1'b1, 8'h12, 8'h00, 1'b0, 1'b0, lat);
    chk("rd_latency", lat, 8);
    n0 = we_log.size();
    do_op(1'b0, 8'h34, 8'h5C, 1'b0, 1'b0, lat);
    check_wlog(n0, 8'h5C);
    do_op(1'b1, 8'h34, 8'h00, 1'b0, 1'b0, lat);

    // random traffic
    for (int k = 0; k < 16; k++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      d  = 8'($urandom);
      n0 = we_log.size();
      do_op(rd, a, d, 1'b0, 1'b0, lat);
      if (rd) chk("rd_latency_rand", lat, 8);
      else check_wlog(n0, d);
    end

    // trigger re-pulsed while program busy: dropped
    n0 = we_log.size();
    do_op(1'b0, 8'h99, 8'h3C, 1'b0, 1'b1, lat);
    check_wlog(n0, 8'h3C);
    do_op(1'b1, 8'h99, 8'h00, 1'b0, 1'b0, lat);

    // STS stuck low: timeout flag, read-array still issued
    force_busy = 1'b1;
    n0 = we_log.size();
    do_op(1'b0, 8'h77, 8'hE1, 1'b1, 1'b0, lat);
    check_wlog(n0, 8'hE1);
    force_busy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", fl_err, 1);
    do_op(1'b1, 8'h77, 8'h00, 1'b0, 1'b0, lat);

    // reset inside program busy
    ta = 8'h56;
    td = 8'hC3;
    n0 = we_log.size();
    @(posedge clk); #1;
    fl_flow = 1'b0; fl_addr = ta; wr_dat = td; fl_trg = 1'b1;
    @(posedge clk); #1;
    fl_trg = 1'b0;
    ref_mem[ta] = td;
    w = 0;
    while (we_log.size() - n0 < 2 && w < 100) begin @(posedge clk); #1; w++; end
    chk("prog_data_issued", we_log.size() - n0, 2);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_ce", sf_ce0, 1);
    chk("rst_mid_we", sf_we, 1);
    chk("rst_mid_oe", sf_oe, 1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    n1 = we_log.size();
    w = 0;
    while (we_log.size() <= n1 && w < 300) begin @(posedge clk); #1; w++; end
    chk("post_rst_cmd_seen", we_log.size() - n1, 1);
    if (we_log.size() > n1) begin
      chk("post_rst_cmd", we_log[n1], 8'hFF);
      chk("post_rst_sts_ready", sts_log[n1], 1);
    end
    repeat (4) @(posedge clk);
    do_op(1'b1, ta, 8'h00, 1'b0, 1'b0, lat);

    repeat (5) @(posedge clk);
    chk("oe_we_overlap", bus_viol, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
